// File: rtl/alu_regfile_pipe.sv
// Two-stage register/immediate ALU with register file, operand bypass from the
// execute stage and a valid/ready backpressured register-read output port.
module alu_regfile_pipe #(
    parameter int  DATA_WIDTH  = 16,
    parameter int  REG_COUNT   = 16,
    localparam int ADDR_WIDTH  = $clog2(REG_COUNT),
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            alu_flags
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_MOV  = 4'd8,
        OP_LDI  = 4'd9,
        OP_RD   = 4'd10,
        OP_ADDI = 4'd11
    } opcode_e;

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

    logic                  exValid_q, exValid_d;
    logic [3:0]            exOp_q, exOp_d;
    logic [ADDR_WIDTH-1:0] exRd_q, exRd_d;
    logic [DATA_WIDTH-1:0] exA_q, exA_d;
    logic [DATA_WIDTH-1:0] exB_q, exB_d;
    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic [3:0]            flags_q, flags_d;

    logic [DATA_WIDTH:0]    addWide, subWide, shlWide, shrWide;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  exResult;
    logic                   exCarry, exOverflow, exWrites, exSetsFlags;
    logic                   exWriteEn, outFree, rdCompletes, exCompletes, accept;
    logic                   immSel;
    logic [DATA_WIDTH-1:0]  opA, opB;

    // Widened adders/shifters expose the carry and the last bit shifted out.
    assign shamt   = exB_q[SHAMT_WIDTH-1:0];
    assign addWide = {1'b0, exA_q} + {1'b0, exB_q};
    assign subWide = {1'b0, exA_q} + {1'b0, ~exB_q} + (DATA_WIDTH+1)'(1);
    assign shlWide = {1'b0, exA_q} << shamt;
    assign shrWide = {exA_q, 1'b0} >> shamt;

    always_comb begin
        exResult    = '0;
        exCarry     = 1'b0;
        exOverflow  = 1'b0;
        exWrites    = 1'b0;
        exSetsFlags = 1'b0;
        case (exOp_q)
            OP_ADD, OP_ADDI: begin
                exResult    = addWide[DATA_WIDTH-1:0];
                exCarry     = addWide[DATA_WIDTH];
                exOverflow  = (exA_q[MSB] == exB_q[MSB]) && (exResult[MSB] != exA_q[MSB]);
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_SUB: begin
                exResult    = subWide[DATA_WIDTH-1:0];
                exCarry     = subWide[DATA_WIDTH];
                exOverflow  = (exA_q[MSB] != exB_q[MSB]) && (exResult[MSB] != exA_q[MSB]);
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_AND: begin
                exResult    = exA_q & exB_q;
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_OR: begin
                exResult    = exA_q | exB_q;
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_XOR: begin
                exResult    = exA_q ^ exB_q;
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_SHL: begin
                exResult    = shlWide[DATA_WIDTH-1:0];
                exCarry     = shlWide[DATA_WIDTH];
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_SHR: begin
                exResult    = shrWide[DATA_WIDTH:1];
                exCarry     = shrWide[0];
                exWrites    = 1'b1;
                exSetsFlags = 1'b1;
            end
            OP_MOV: begin
                exResult = exA_q;
                exWrites = 1'b1;
            end
            OP_LDI: begin
                exResult = exB_q;
                exWrites = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Only RD can stall: it needs a free output slot to complete.
    assign exWriteEn   = exValid_q && exWrites;
    assign outFree     = !outValid_q || out_ready;
    assign rdCompletes = exValid_q && (exOp_q == OP_RD) && outFree;
    assign exCompletes = exValid_q && ((exOp_q != OP_RD) || outFree);
    assign in_ready    = reset && (!exValid_q || exCompletes);
    assign accept      = in_valid && in_ready;

    assign immSel = (in_op == OP_LDI) || (in_op == OP_ADDI);
    assign opA    = (exWriteEn && (exRd_q == in_rs1)) ? exResult : rf_q[in_rs1];
    assign opB    = immSel ? in_imm :
                    ((exWriteEn && (exRd_q == in_rs2)) ? exResult : rf_q[in_rs2]);

    always_comb begin
        exValid_d  = exValid_q;
        exOp_d     = exOp_q;
        exRd_d     = exRd_q;
        exA_d      = exA_q;
        exB_d      = exB_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        flags_d    = flags_q;

        if (accept) begin
            exValid_d = 1'b1;
            exOp_d    = in_op;
            exRd_d    = in_rd;
            exA_d     = opA;
            exB_d     = opB;
        end else if (exCompletes) begin
            exValid_d = 1'b0;
        end

        if (rdCompletes) begin
            outValid_d = 1'b1;
            outData_d  = exA_q;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end

        if (exWriteEn && exSetsFlags) begin
            flags_d = {(exResult == '0), exResult[MSB], exCarry, exOverflow};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            exValid_q  <= 1'b0;
            exOp_q     <= '0;
            exRd_q     <= '0;
            exA_q      <= '0;
            exB_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            flags_q    <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            exValid_q  <= exValid_d;
            exOp_q     <= exOp_d;
            exRd_q     <= exRd_d;
            exA_q      <= exA_d;
            exB_q      <= exB_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            flags_q    <= flags_d;
            if (exWriteEn) begin
                rf_q[exRd_q] <= exResult;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign alu_flags = flags_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe: directed scenarios plus a random
// instruction stream, with read results checked through an in-order scoreboard.
module tb_alu_regfile_pipe;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd9;
    localparam logic [3:0] OP_RD   = 4'd10;
    localparam logic [3:0] OP_ADDI = 4'd11;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  alu_flags;

    int          assertCount = 0;
    int          failCount   = 0;
    int          totalStalls = 0;
    logic [15:0] modelRf [16];
    logic [3:0]  modelFlags;
    logic [15:0] sbQueue [$];
    logic [15:0] expData;
    logic [15:0] lastOut = '0;

    always #5 clk = ~clk;

    alu_regfile_pipe #(.DATA_WIDTH(16), .REG_COUNT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .alu_flags (alu_flags)
    );

    // A transfer happens at the coming rising edge when both are high mid-cycle.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            assertCount++;
            if (sbQueue.size() == 0) begin
                failCount++;
                $display("[TB] FAIL out_unexpected: got %h, required no output", out_data);
            end else begin
                expData = sbQueue.pop_front();
                if (out_data !== expData) begin
                    failCount++;
                    $display("[TB] FAIL out_data: got %h, required %h", out_data, expData);
                end
                lastOut = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) modelRf[i] = '0;
        modelFlags = '0;
        sbQueue.delete();
    endtask

    task automatic modelExec(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                             input logic [3:0] rs2, input logic [15:0] imm);
        logic [15:0] a, b, r;
        logic        c, v, w, f;
        int          s;
        a = modelRf[rs1];
        b = (op == OP_LDI || op == OP_ADDI) ? imm : modelRf[rs2];
        s = int'(b[3:0]);
        r = '0; c = 1'b0; v = 1'b0; w = 1'b1; f = 1'b1;
        case (op)
            4'd1, 4'd11: begin
                r = a + b;
                c = (32'(a) + 32'(b)) > 32'h0000FFFF;
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd2: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin
                r = a << s;
                c = (s == 0) ? 1'b0 : a[16 - s];
            end
            4'd7: begin
                r = a >> s;
                c = (s == 0) ? 1'b0 : a[s - 1];
            end
            4'd8: begin r = a; f = 1'b0; end
            4'd9: begin r = b; f = 1'b0; end
            4'd10: begin
                sbQueue.push_back(a);
                w = 1'b0; f = 1'b0;
            end
            default: begin w = 1'b0; f = 1'b0; end
        endcase
        if (w) modelRf[rd] = r;
        if (f) modelFlags = {(r == 16'h0), r[15], c, v};
    endtask

    // Holds the instruction until accepted; frees a stuck output after 3 stalls.
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                 input logic [3:0] rs2, input logic [15:0] imm, output int stalls);
        bit accepted;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        stalls   = 0;
        accepted = 1'b0;
        for (int k = 0; k < 64 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
            end else begin
                stalls++;
                step();
                if (stalls >= 3) out_ready = 1'b1;
            end
        end
        assertCount++;
        if (!accepted) begin
            failCount++;
            $display("[TB] FAIL accept_timeout: op %0d not accepted, required acceptance", op);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [15:0] imm);
        int s;
        modelExec(op, rd, rs1, rs2, imm);
        applyStimulus(op, rd, rs1, rs2, imm, s);
        totalStalls += s;
    endtask

    task automatic waitDrain(input string name);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (sbQueue.size() != 0 && k < 200) begin
            step();
            k++;
        end
        assertCount++;
        if (sbQueue.size() != 0) begin
            failCount++;
            $display("[TB] FAIL %s_drain: %0d results pending, required 0", name, sbQueue.size());
        end
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = OP_NOP; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready); end
        assertCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
        assertCount++;
        if (alu_flags !== 4'h0) begin failCount++; $display("[TB] FAIL reset_flags: got %b, required 0000", alu_flags); end
        assertCount++;
        if (out_data !== 16'h0) begin failCount++; $display("[TB] FAIL reset_out_data: got %h, required 0000", out_data); end
        step();
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL idle_in_ready: got %b, required 1", in_ready); end
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        totalStalls = 0;
        issue(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h0005);
        issue(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0003);
        issue(OP_ADD, 4'd3, 4'd1, 4'd2, 16'h0000);
        issue(OP_RD,  4'd0, 4'd3, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b0000) begin failCount++; $display("[TB] FAIL basic_flags: got %b, required 0000", alu_flags); end
        assertCount++;
        if (totalStalls !== 0) begin failCount++; $display("[TB] FAIL basic_stalls: got %0d, required 0", totalStalls); end
        waitDrain("basic");
        assertCount++;
        if (lastOut !== 16'h0008) begin failCount++; $display("[TB] FAIL basic_read: got %h, required 0008", lastOut); end
    endtask

    task automatic test_back_to_back();
        totalStalls = 0;
        issue(OP_LDI,  4'd4, 4'd0, 4'd0, 16'h7FFF);
        issue(OP_ADDI, 4'd4, 4'd4, 4'd0, 16'h0001);
        issue(OP_RD,   4'd0, 4'd4, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b0101) begin failCount++; $display("[TB] FAIL b2b_flags: got %b, required 0101", alu_flags); end
        assertCount++;
        if (totalStalls !== 0) begin failCount++; $display("[TB] FAIL b2b_stalls: got %0d, required 0", totalStalls); end
        waitDrain("b2b");
        assertCount++;
        if (lastOut !== 16'h8000) begin failCount++; $display("[TB] FAIL b2b_read: got %h, required 8000", lastOut); end
    endtask

    task automatic test_sub();
        issue(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h0003);
        issue(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0005);
        issue(OP_SUB, 4'd5, 4'd1, 4'd2, 16'h0000);
        issue(OP_RD,  4'd0, 4'd5, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b0100) begin failCount++; $display("[TB] FAIL sub_neg_flags: got %b, required 0100", alu_flags); end
        issue(OP_SUB, 4'd5, 4'd2, 4'd1, 16'h0000);
        issue(OP_RD,  4'd0, 4'd5, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b0010) begin failCount++; $display("[TB] FAIL sub_pos_flags: got %b, required 0010", alu_flags); end
        issue(OP_SUB, 4'd6, 4'd1, 4'd1, 16'h0000);
        issue(OP_RD,  4'd0, 4'd6, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b1010) begin failCount++; $display("[TB] FAIL sub_zero_flags: got %b, required 1010", alu_flags); end
        waitDrain("sub");
        assertCount++;
        if (lastOut !== 16'h0000) begin failCount++; $display("[TB] FAIL sub_read: got %h, required 0000", lastOut); end
    endtask

    task automatic test_shift();
        issue(OP_LDI, 4'd7, 4'd0, 4'd0, 16'h8001);
        issue(OP_LDI, 4'd8, 4'd0, 4'd0, 16'h0001);
        issue(OP_SHL, 4'd9, 4'd7, 4'd8, 16'h0000);
        issue(OP_MOV, 4'd13, 4'd7, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b0010) begin failCount++; $display("[TB] FAIL shl_flags: got %b, required 0010", alu_flags); end
        step();
        assertCount++;
        if (alu_flags !== 4'b0010) begin failCount++; $display("[TB] FAIL mov_keeps_flags: got %b, required 0010", alu_flags); end
        issue(OP_LDI, 4'd10, 4'd0, 4'd0, 16'h0003);
        issue(OP_LDI, 4'd11, 4'd0, 4'd0, 16'h0000);
        issue(OP_SHR, 4'd12, 4'd10, 4'd11, 16'h0000);
        issue(OP_MOV, 4'd14, 4'd7, 4'd0, 16'h0000);
        assertCount++;
        if (alu_flags !== 4'b0000) begin failCount++; $display("[TB] FAIL shr_flags: got %b, required 0000", alu_flags); end
        step();
        assertCount++;
        if (alu_flags !== 4'b0000) begin failCount++; $display("[TB] FAIL mov2_keeps_flags: got %b, required 0000", alu_flags); end
        issue(OP_RD, 4'd0, 4'd9, 4'd0, 16'h0000);
        issue(OP_RD, 4'd0, 4'd12, 4'd0, 16'h0000);
        issue(OP_RD, 4'd0, 4'd13, 4'd0, 16'h0000);
        waitDrain("shift");
        assertCount++;
        if (lastOut !== 16'h8001) begin failCount++; $display("[TB] FAIL shift_read: got %h, required 8001", lastOut); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(OP_RD, 4'd0, 4'd1, 4'd0, 16'h0000);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            assertCount++;
            if (out_valid !== 1'b1 || out_data !== 16'h0003) begin
                failCount++;
                $display("[TB] FAIL bp_hold: got valid %b data %h, required valid 1 data 0003", out_valid, out_data);
            end
        end
        step();
        modelExec(OP_RD, 4'd0, 4'd2, 4'd0, 16'h0000);
        in_valid = 1'b1; in_op = OP_RD; in_rd = 4'd0; in_rs1 = 4'd2; in_rs2 = 4'd0; in_imm = '0;
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL bp_accept_second: got %b, required 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            assertCount++;
            if (in_ready !== 1'b0 || out_data !== 16'h0003) begin
                failCount++;
                $display("[TB] FAIL bp_stall: got in_ready %b data %h, required in_ready 0 data 0003", in_ready, out_data);
            end
        end
        step();
        out_ready = 1'b1;
        waitDrain("bp");
        assertCount++;
        if (lastOut !== 16'h0005) begin failCount++; $display("[TB] FAIL bp_second_read: got %h, required 0005", lastOut); end
    endtask

    task automatic test_reset_midflight();
        int s;
        out_ready = 1'b0;
        applyStimulus(OP_RD, 4'd0, 4'd3, 4'd0, 16'h0000, s);
        applyStimulus(OP_ADD, 4'd15, 4'd4, 4'd4, 16'h0000, s);
        reset = 1'b0;
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL rst_in_ready: got %b, required 0", in_ready); end
        @(negedge clk);
        assertCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_out_valid: got %b, required 0", out_valid); end
        assertCount++;
        if (alu_flags !== 4'h0) begin failCount++; $display("[TB] FAIL rst_flags: got %b, required 0000", alu_flags); end
        step();
        reset = 1'b1;
        modelReset();
        out_ready = 1'b1;
        for (int r = 0; r < 16; r++) issue(OP_RD, 4'd0, 4'(r), 4'd0, 16'h0000);
        waitDrain("rst");
    endtask

    task automatic test_random();
        logic [3:0]  op, rd, rs1, rs2, expFlags;
        logic [15:0] imm;
        for (int i = 0; i < 80; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            op  = 4'($urandom_range(0, 15));
            rd  = 4'($urandom_range(0, 15));
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
            imm = 16'($urandom);
            expFlags = modelFlags;
            issue(op, rd, rs1, rs2, imm);
            assertCount++;
            if (alu_flags !== expFlags) begin
                failCount++;
                $display("[TB] FAIL rand_flags step %0d: got %b, required %b", i, alu_flags, expFlags);
            end
        end
        out_ready = 1'b1;
        for (int r = 0; r < 16; r++) issue(OP_RD, 4'd0, 4'(r), 4'd0, 16'h0000);
        waitDrain("rand");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_sub();
        test_shift();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
